// File: rtl/log_conv_pkg.sv
// Shared types and sizing helpers for the linear-to-log converter.
// LINEAR_TO_LOG_ROUND_EN adds one extra iteration used as a round bit.
package log_conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Squaring datapath width: 2 integer bits, fraction, guard bits.
    function automatic int unsigned calc_p(input int unsigned frac_w, input int unsigned guard_w);
        return frac_w + guard_w + 2;
    endfunction

    function automatic int unsigned iter_count(input int unsigned f_w);
`ifdef LINEAR_TO_LOG_ROUND_EN
        return f_w + 1;
`else
        return f_w;
`endif
    endfunction

endpackage

// File: rtl/log2_square_step.sv
// One log2 fraction bit: square x (2.P-2 fixed point), renormalise into [1,2).
module log2_square_step #(
    parameter int unsigned P = 14
) (
    input  logic [P-1:0] x,
    output logic [P-1:0] x_next,
    output logic         log_bit
);

    logic [2*P-1:0] x_wide;
    logic [P-1:0]   sq;

    assign x_wide = (2*P)'(x);
    // Product has 4 integer bits; keep 2 integer bits and truncate the low end.
    assign sq      = P'((x_wide * x_wide) >> (P - 2));
    assign log_bit = sq[P-1];
    assign x_next  = log_bit ? {1'b0, sq[P-1:1]} : sq;

endmodule

// File: rtl/float_signed_to_log_number_unpacked.sv
// Unpacked signed float to unpacked log number, one log fraction bit per cycle.
// Optional LINEAR_TO_LOG_ROUND_EN: extra round iteration with exponent carry.
module float_signed_to_log_number_unpacked
    import log_conv_pkg::*;
#(
    parameter int unsigned M     = 5,
    parameter int unsigned F     = 10,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned GUARD = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sign,
    input  logic            in_isInf,
    input  logic            in_isZero,
    input  logic [M-1:0]    in_exp,
    input  logic [FRAC-1:0] in_frac,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_sign,
    output logic            out_isInf,
    output logic            out_isZero,
    output logic [M-1:0]    out_signedLogExp,
    output logic [F-1:0]    out_logFrac
);

    localparam int unsigned P     = calc_p(FRAC, GUARD);
    localparam int unsigned ITERS = iter_count(F);
    localparam int unsigned CW    = $clog2(ITERS + 1);

    state_t            state, state_next;
    logic [P-1:0]      x_q, x_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ITERS-1:0]  acc_q, acc_d;
    logic              sign_q, sign_d;
    logic              inf_q, inf_d;
    logic              zero_q, zero_d;
    logic [M-1:0]      exp_q, exp_d;

    logic [P-1:0]      step_x;
    logic              step_bit;

    logic              res_inf;
    logic [M-1:0]      res_exp;
    logic [F-1:0]      res_frac;
    logic              load_out;

    log2_square_step #(.P(P)) u_step (
        .x       (x_q),
        .x_next  (step_x),
        .log_bit (step_bit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and working-register update.
    always_comb begin
        state_next = state;
        x_d        = x_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        sign_d     = sign_q;
        inf_d      = inf_q;
        zero_d     = zero_q;
        exp_d      = exp_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_d = in_sign;
                    inf_d  = in_isInf;
                    zero_d = in_isZero;
                    exp_d  = in_exp;
                    x_d    = {2'b01, in_frac, {GUARD{1'b0}}};
                    cnt_d  = CW'(ITERS - 1);
                    acc_d  = '0;
                    state_next = (in_isInf || in_isZero) ? DONE : ITER;
                end
            end
            ITER: begin
                x_d   = step_x;
                acc_d = acc_q | (ITERS'(step_bit) << cnt_q);
                if (cnt_q == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef LINEAR_TO_LOG_ROUND_EN
    localparam logic [M-1:0] EXP_MAX = {1'b0, {(M-1){1'b1}}};
    logic [F:0] rounded;
    assign rounded = (F+1)'(acc_d[ITERS-1:1]) + (F+1)'(acc_d[0]);
`endif

    // Final result formatting from the completed bit accumulator.
    always_comb begin
        res_inf  = inf_d;
        res_exp  = '0;
        res_frac = '0;
        if (!inf_d && !zero_d) begin
`ifdef LINEAR_TO_LOG_ROUND_EN
            if (rounded[F]) begin
                if (exp_d == EXP_MAX) begin
                    res_inf = 1'b1;
                    res_exp = exp_d;
                end else begin
                    res_exp = exp_d + M'(1);
                end
            end else begin
                res_frac = rounded[F-1:0];
                res_exp  = exp_d;
            end
`else
            res_frac = acc_d[F-1:0];
            res_exp  = exp_d;
`endif
        end
    end

    assign load_out = (state_next == DONE) && (state != DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q              <= '0;
            cnt_q            <= '0;
            acc_q            <= '0;
            sign_q           <= 1'b0;
            inf_q            <= 1'b0;
            zero_q           <= 1'b0;
            exp_q            <= '0;
            in_ready         <= 1'b1;
            out_valid        <= 1'b0;
            out_sign         <= 1'b0;
            out_isInf        <= 1'b0;
            out_isZero       <= 1'b0;
            out_signedLogExp <= '0;
            out_logFrac      <= '0;
        end else begin
            x_q       <= x_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            sign_q    <= sign_d;
            inf_q     <= inf_d;
            zero_q    <= zero_d;
            exp_q     <= exp_d;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            if (load_out) begin
                out_sign         <= sign_d;
                out_isInf        <= res_inf;
                out_isZero       <= zero_d;
                out_signedLogExp <= res_exp;
                out_logFrac      <= res_frac;
            end
        end
    end

endmodule

// File: tb/tb_float_signed_to_log_number_unpacked.sv
// Randomised bench for float_signed_to_log_number_unpacked against a log2 reference model.
// Honours LINEAR_TO_LOG_ROUND_EN when defined.
module tb_float_signed_to_log_number_unpacked;

    localparam int M     = 5;
    localparam int F     = 10;
    localparam int FRAC  = 8;
    localparam int GUARD = 4;
    localparam int P     = FRAC + GUARD + 2;
`ifdef LINEAR_TO_LOG_ROUND_EN
    localparam int ITERS = F + 1;
`else
    localparam int ITERS = F;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic            in_sign;
    logic            in_isInf;
    logic            in_isZero;
    logic [M-1:0]    in_exp;
    logic [FRAC-1:0] in_frac;
    logic            out_valid;
    logic            out_ready;
    logic            out_sign;
    logic            out_isInf;
    logic            out_isZero;
    logic [M-1:0]    out_signedLogExp;
    logic [F-1:0]    out_logFrac;

    int n_checks = 0;
    int n_fail   = 0;

    float_signed_to_log_number_unpacked #(.M(M), .F(F), .FRAC(FRAC), .GUARD(GUARD)) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_sign          (in_sign),
        .in_isInf         (in_isInf),
        .in_isZero        (in_isZero),
        .in_exp           (in_exp),
        .in_frac          (in_frac),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_sign         (out_sign),
        .out_isInf        (out_isInf),
        .out_isZero       (out_isZero),
        .out_signedLogExp (out_signedLogExp),
        .out_logFrac      (out_logFrac)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // log2 of 1.frac by repeated squaring in plain integer arithmetic.
    function automatic void model(input logic inf, input logic zero, input logic [M-1:0] e,
                                  input logic [FRAC-1:0] f, output logic [M-1:0] res_exp,
                                  output logic [F-1:0] res_frac, output logic res_inf);
        longint one;
        longint x;
        longint bits;
        res_inf  = inf;
        res_exp  = '0;
        res_frac = '0;
        if (inf || zero) return;
        one  = longint'(1) << (P - 2);
        x    = longint'(256 + int'(f)) << GUARD;
        bits = 0;
        for (int i = 0; i < ITERS; i++) begin
            x = (x * x) / one;
            if (x >= 2 * one) begin
                bits = bits * 2 + 1;
                x    = x / 2;
            end else begin
                bits = bits * 2;
            end
        end
`ifdef LINEAR_TO_LOG_ROUND_EN
        bits = bits / 2 + (bits % 2);
        if (bits >= (longint'(1) << F)) begin
            res_frac = '0;
            if ($signed(e) == 15) begin
                res_inf = 1'b1;
                res_exp = e;
            end else begin
                res_exp = e + 5'd1;
            end
        end else begin
            res_frac = F'(bits);
            res_exp  = e;
        end
`else
        res_frac = F'(bits);
        res_exp  = e;
`endif
    endfunction

    // Starts and ends at a falling edge.
    task automatic do_conv(input logic s, input logic inf, input logic zero,
                           input logic [M-1:0] e, input logic [FRAC-1:0] f, input int hold);
        logic [M-1:0] want_exp;
        logic [F-1:0] want_frac;
        logic         want_inf;
        int           cyc;
        int           want_lat;
        model(inf, zero, e, f, want_exp, want_frac, want_inf);
        want_lat = (inf || zero) ? 1 : ITERS + 1;
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_sign = s; in_isInf = inf; in_isZero = zero;
        in_exp = e; in_frac = f; out_ready = 1'b0;
        @(posedge clock);
        cyc = 1;
        @(negedge clock);
        in_valid = 1'b0;
        in_sign = 1'($urandom); in_exp = M'($urandom); in_frac = FRAC'($urandom);
        in_isInf = 1'($urandom); in_isZero = 1'($urandom);
        while (!out_valid && cyc < 64) begin
            in_valid = 1'($urandom);
            @(posedge clock);
            cyc++;
            @(negedge clock);
        end
        in_valid = 1'b0;
        check("latency", cyc, want_lat);
        check("out_valid", out_valid, 1);
        check("sign", out_sign, s);
        check("is_inf", out_isInf, want_inf);
        check("is_zero", out_isZero, zero);
        check("log_exp", out_signedLogExp, want_exp);
        check("log_frac", out_logFrac, want_frac);
        check("in_ready_done", in_ready, 0);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clock);
                @(negedge clock);
            end
            check("hold_valid", out_valid, 1);
            check("hold_frac", out_logFrac, want_frac);
            check("hold_exp", out_signedLogExp, want_exp);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [M-1:0] e;
        logic [FRAC-1:0] f;
        logic sp;
        reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_isInf = 1'b0; in_isZero = 1'b0;
        in_exp = '0; in_frac = '0; out_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_log_frac", out_logFrac, 0);
        check("rst_log_exp", out_signedLogExp, 0);
        check("rst_flags", {out_sign, out_isInf, out_isZero}, 0);
        reset = 1'b0;

        // Directed cases.
        do_conv(1'b0, 1'b0, 1'b0, 5'd3, 8'h00, 0);
        check("pow2_exact", out_logFrac, 0);
        do_conv(1'b1, 1'b0, 1'b0, 5'b11110, 8'h80, 0);
        check("acc_1p5", (out_logFrac >= 10'd598 && out_logFrac <= 10'd600), 1);
        do_conv(1'b0, 1'b0, 1'b1, 5'd7, 8'h5A, 0);
        do_conv(1'b1, 1'b1, 1'b0, 5'd9, 8'hC3, 0);
        do_conv(1'b0, 1'b0, 1'b0, 5'd1, 8'h40, 5);
        do_conv(1'b0, 1'b0, 1'b0, 5'd15, 8'hFF, 0);
        do_conv(1'b0, 1'b0, 1'b0, 5'b10000, 8'h01, 2);

        // Reset while iterating aborts the conversion.
        in_valid = 1'b1; in_sign = 1'b1; in_exp = 5'd4; in_frac = 8'h33;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clock);
            @(negedge clock);
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        do_conv(1'b1, 1'b0, 1'b0, 5'd4, 8'h33, 1);

        // Randomised conversions.
        for (int i = 0; i < 40; i++) begin
            e  = M'($urandom);
            f  = FRAC'($urandom);
            sp = ($urandom_range(0, 7) == 0);
            if (sp && $urandom_range(0, 1) == 1)
                do_conv(1'($urandom), 1'b1, 1'b0, e, f, $urandom_range(0, 3));
            else if (sp)
                do_conv(1'($urandom), 1'b0, 1'b1, e, f, $urandom_range(0, 3));
            else
                do_conv(1'($urandom), 1'b0, 1'b0, e, f, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
